// File: rtl/edge_trigger_if.sv
// rtl/edge_trigger_if.sv - enable/input/edge bundle for edge_trigger (master drives En and IN)
interface edge_trigger_if #(
  parameter int WIDTH = 1
);
  logic             En;
  logic [WIDTH-1:0] IN;
  logic [WIDTH-1:0] EDGE;

  modport master (output En, output IN, input EDGE);
  modport slave  (input En, input IN, output EDGE);
endinterface

// File: rtl/edge_trigger.sv
// rtl/edge_trigger.sv - clock-enabled per-bit edge detector; EDGE_TRIGGER_SYNC_EN adds a 2-flop input synchroniser
module edge_trigger #(
  parameter bit POSEDGE = 1'b1,
  parameter int WIDTH   = 1
) (
  input  logic          CLK,
  input  logic          nRESET,
  edge_trigger_if.slave bus
);

  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] w_s;

`ifdef EDGE_TRIGGER_SYNC_EN
  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_sync1 <= {WIDTH{POSEDGE}};
      r_sync2 <= {WIDTH{POSEDGE}};
    end else if (bus.En) begin
      r_sync1 <= bus.IN;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = r_sync2;
`else
  assign w_s = bus.IN;
`endif

  // Resetting to the detected polarity's "after" level suppresses a first-sample edge.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_prev <= {WIDTH{POSEDGE}};
    end else if (bus.En) begin
      r_prev <= w_s;
    end
  end

  generate
    if (POSEDGE) begin : g_rise
      assign bus.EDGE = {WIDTH{bus.En}} & w_s & ~r_prev;
    end else begin : g_fall
      assign bus.EDGE = {WIDTH{bus.En}} & ~w_s & r_prev;
    end
  endgenerate

endmodule

// File: tb/tb_edge_trigger.sv
// tb/tb_edge_trigger.sv - randomized self-checking bench for edge_trigger against a sample-history model
module tb_edge_trigger;

  logic       CLK = 1'b0;
  logic       nRESET;
  logic       en;
  logic [3:0] in_v [4];

  int checks = 0;
  int errors = 0;

  logic [3:0] m_prev [4];
  logic [3:0] m_h1   [4];
  logic [3:0] m_h2   [4];

  always #5 CLK = ~CLK;

  edge_trigger_if #(.WIDTH(1)) if0 ();
  edge_trigger_if #(.WIDTH(1)) if1 ();
  edge_trigger_if #(.WIDTH(2)) if2 ();
  edge_trigger_if #(.WIDTH(4)) if3 ();

  assign if0.En = en;
  assign if1.En = en;
  assign if2.En = en;
  assign if3.En = en;
  assign if0.IN = in_v[0][0:0];
  assign if1.IN = in_v[1][0:0];
  assign if2.IN = in_v[2][1:0];
  assign if3.IN = in_v[3];

  edge_trigger #(1'b0, 1) u0 (.CLK(CLK), .nRESET(nRESET), .bus(if0.slave));
  edge_trigger #(1'b1, 1) u1 (.CLK(CLK), .nRESET(nRESET), .bus(if1.slave));
  edge_trigger #(1'b0, 2) u2 (.CLK(CLK), .nRESET(nRESET), .bus(if2.slave));
  edge_trigger #(1'b1, 4) u3 (.CLK(CLK), .nRESET(nRESET), .bus(if3.slave));

  function automatic bit pe(input int k);
    return (k == 1) || (k == 3);
  endfunction

  function automatic logic [3:0] mask(input int k);
    case (k)
      2:       return 4'b0011;
      3:       return 4'b1111;
      default: return 4'b0001;
    endcase
  endfunction

  function automatic logic [3:0] dut_edge(input int k);
    case (k)
      0:       return {3'b000, if0.EDGE};
      1:       return {3'b000, if1.EDGE};
      2:       return {2'b00, if2.EDGE};
      default: return if3.EDGE;
    endcase
  endfunction

  // Detected level: the raw input, or the enabled sample taken two enabled cycles ago.
  function automatic logic [3:0] model_s(input int k);
`ifdef EDGE_TRIGGER_SYNC_EN
    return m_h2[k];
`else
    return in_v[k] & mask(k);
`endif
  endfunction

  function automatic logic [3:0] model_edge(input int k);
    logic [3:0] s;
    s = model_s(k);
    if (!en) return 4'b0000;
    if (pe(k)) return s & ~m_prev[k] & mask(k);
    return ~s & m_prev[k] & mask(k);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_prev[k] = pe(k) ? mask(k) : 4'b0000;
      m_h1[k]   = m_prev[k];
      m_h2[k]   = m_prev[k];
    end
  endtask

  task automatic model_clock();
    logic [3:0] s;
    if (!nRESET || !en) return;
    for (int k = 0; k < 4; k++) begin
      s         = model_s(k);
      m_h2[k]   = m_h1[k];
      m_h1[k]   = in_v[k] & mask(k);
      m_prev[k] = s;
    end
  endtask

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 4; k++)
      check($sformatf("%s_dut%0d", tag, k), dut_edge(k), model_edge(k));
  endtask

  task automatic cycle(input logic e, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] d, input string tag);
    @(negedge CLK);
    en = e; in_v[0] = a; in_v[1] = b; in_v[2] = c; in_v[3] = d;
    #1 check_all(tag);
    @(posedge CLK);
    model_clock();
  endtask

  initial begin
    logic [3:0] r [4];
    nRESET = 1'b0;
    en     = 1'b0;
    in_v[0] = 4'h1; in_v[1] = 4'h1; in_v[2] = 4'h3; in_v[3] = 4'hF;
    model_reset();
    #2 check_all("reset");
    @(negedge CLK);
    nRESET = 1'b1;

    cycle(1'b1, 4'h1, 4'h1, 4'h3, 4'hF, "first_en");
    cycle(1'b1, 4'h0, 4'h0, 4'h1, 4'h0, "fall");
`ifndef EDGE_TRIGGER_SYNC_EN
    check("t1_fall_pulse", {3'b000, if0.EDGE}, 4'h1);
    check("t5_msb_fall", {2'b00, if2.EDGE}, 4'h2);
`endif
    cycle(1'b1, 4'h0, 4'h0, 4'h1, 4'h0, "hold");
    cycle(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, "lsb_fall");
    cycle(1'b1, 4'h1, 4'h1, 4'h3, 4'hA, "rise");
`ifndef EDGE_TRIGGER_SYNC_EN
    check("t2_rise_fall_det", {3'b000, if0.EDGE}, 4'h0);
    check("t2_rise_pulse", {3'b000, if1.EDGE}, 4'h1);
`endif
    cycle(1'b1, 4'h1, 4'h1, 4'h3, 4'hA, "steady");
    cycle(1'b0, 4'h0, 4'h0, 4'h0, 4'h5, "en0_a");
    cycle(1'b0, 4'h0, 4'h0, 4'h0, 4'h5, "en0_b");
    cycle(1'b1, 4'h0, 4'h0, 4'h0, 4'h5, "en_back");
`ifndef EDGE_TRIGGER_SYNC_EN
    check("t3_late_fall", {3'b000, if0.EDGE}, 4'h1);
`endif
    cycle(1'b0, 4'h1, 4'h1, 4'h3, 4'hF, "glitch_a");
    cycle(1'b0, 4'h0, 4'h0, 4'h0, 4'h5, "glitch_b");
    cycle(1'b1, 4'h0, 4'h0, 4'h0, 4'h5, "glitch_gone");
    cycle(1'b1, 4'h0, 4'h0, 4'h0, 4'h5, "settle");

    for (int k = 0; k < 4; k++) r[k] = in_v[k];
    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < 4; k++)
        if ($urandom_range(0, 2) == 0) r[k] = r[k] ^ 4'($urandom_range(1, 15));
      if (n == 300 || n == 450) begin
        @(negedge CLK);
        en = 1'b1;
        for (int k = 0; k < 4; k++) in_v[k] = r[k];
        #2 nRESET = 1'b0;
        #1 model_reset();
        check_all("async_reset");
        @(negedge CLK);
        #1 check_all("in_reset");
        @(negedge CLK);
        nRESET = 1'b1;
        #1 check_all("reset_release");
        @(posedge CLK);
        model_clock();
      end else begin
        cycle(($urandom_range(0, 3) != 0), r[0], r[1], r[2], r[3], "rand");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
